matrix_slot_manager: RTL and testbench
======================================

Name: matrix_slot_manager

Overview:
- Owns the matrix storage table: NUM_SLOTS fixed-stride BRAM regions, each with valid bit and dimensions.
- Serves the alloc/commit handshake used by the generate and input modes: reserves a slot, returns its base address, then records m×n on commit.
- Provides a registered lookup port for the display and compute modes.
- Sits between the mode FSMs and BRAM; it never touches matrix data itself.

Parameters:
- NUM_SLOTS, 8, number of matrix slots (2..16).
- ADDR_WIDTH, `BRAM_ADDR_WIDTH, BRAM address width.
- SLOT_STRIDE, 32, elements per slot region; base = slot*SLOT_STRIDE. NUM_SLOTS*SLOT_STRIDE must not exceed 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  level request; requester holds high until alloc_valid
- alloc_cancel  in  1  pulse; releases the outstanding reservation (mode exit)
- alloc_valid  out  1  one-cycle grant pulse
- alloc_fail  out  1  one-cycle pulse; no slot available
- alloc_slot  out  4  granted slot, stable until the next grant
- alloc_addr  out  ADDR_WIDTH  granted base address, stable until the next grant
- commit_req  in  1  pulse; commit the reserved slot
- commit_slot  in  4  slot being committed
- commit_m  in  4  row count
- commit_n  in  4  column count
- commit_addr  in  ADDR_WIDTH  base address; checked against the reservation
- q_slot  in  4  lookup index
- q_valid  out  1  looked-up slot holds a committed matrix
- q_m  out  4  looked-up row count
- q_n  out  4  looked-up column count
- q_addr  out  ADDR_WIDTH  looked-up base address
- slot_count  out  5  number of committed slots
- error_code  out  4  last error, `ERR_* encoding
- busy  out  1  reservation outstanding

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; table valid bits cleared; victim pointer 0; error_code = `ERR_NONE; FSM enters IDLE.
- IDLE:
  - If alloc_req is high and armed, go to SEARCH.
  - "Armed" means alloc_req was seen low for at least one cycle since the last grant or fail. A requester that registers its request therefore cannot double-allocate.
- SEARCH (1 cycle):
  - Select the lowest-index slot that is neither valid nor reserved.
  - If none is free, apply the overwrite rule (see Optional Feature).
  - On success: mark the slot reserved, register alloc_slot/alloc_addr, go to GRANT.
  - On failure: pulse alloc_fail, set error_code = `ERR_NO_SLOT, return to IDLE.
- GRANT: alloc_valid = 1 for exactly one cycle, then go to WAIT_COMMIT. Grant latency is 2 cycles after the first armed alloc_req cycle.
- WAIT_COMMIT:
  - Valid commit: commit_req with commit_slot == reserved slot, commit_addr == alloc_addr, m and n both nonzero, and m*n ≤ SLOT_STRIDE. Writes valid/m/n, clears reserved, updates slot_count (saturates at NUM_SLOTS), error_code = `ERR_NONE, goes to IDLE.
  - Any other commit: error_code = `ERR_COMMIT; the reservation is kept.
  - alloc_cancel, or a fresh armed alloc_req: clear reserved, go to IDLE. A new request is served on the following pass.
- commit_req outside WAIT_COMMIT: ignored, error_code = `ERR_COMMIT.
- alloc_cancel in the same cycle as commit_req: the commit wins.
- Overwrite of a valid slot: slot_count is unchanged; the slot stays valid with its old dims until the new commit.
- Lookup:
  - 1-cycle registered read of q_slot.
  - q_slot ≥ NUM_SLOTS returns q_valid = 0 and zero fields.
  - A same-cycle commit to q_slot returns the old contents; new contents appear the next cycle.
- Base address is always slot*SLOT_STRIDE, computed at ADDR_WIDTH and never stored per slot.

Optional Feature:
- Macro: SLOT_OVERWRITE_EN.
- Defined: when every slot is valid and none is reserved, SEARCH selects the slot at the victim pointer. The pointer then advances modulo NUM_SLOTS (round-robin, oldest-first) and the grant succeeds.
- Undefined: a full table always produces alloc_fail with `ERR_NO_SLOT, and the victim pointer logic is not synthesized.

Decomposition:
- matrix_pkg.vh:
  - `ERR_NO_SLOT and `ERR_COMMIT codes, alongside existing `ERR_NONE and `ERR_DIM_RANGE.
  - MSM state encodings (IDLE, SEARCH, GRANT, WAIT_COMMIT).
  - Default SLOT_STRIDE.
- One natural sub-module: slot_priority_encoder. It takes the combinational free-mask and returns the lowest free index plus a found flag, and is reused by any future resource pools.

Test Plan:
- Reset, then hold alloc_req high → alloc_valid 2 cycles later with slot 0, addr 0. Commit (0, m=3, n=4, addr 0) → q_slot=0 reads valid, 3, 4, 0; slot_count = 1.
- Hold alloc_req high for 5 cycles after a grant → exactly one alloc_valid. Drop req 1 cycle, raise again → slot 1, addr 32.
- Commit with slot 2 while slot 1 is reserved → error_code = `ERR_COMMIT, still busy. Correct commit → busy = 0, slot_count increments.
- Commit m=6, n=6 (36 > 32) → `ERR_COMMIT. Commit m=0 → `ERR_COMMIT. Then alloc_cancel → busy = 0 and the slot is reusable (next grant returns the same slot).
- Fill all 8 slots, then alloc:
  - without SLOT_OVERWRITE_EN → alloc_fail, `ERR_NO_SLOT;
  - with it → slots 0, 1, 2 granted in turn; slot_count stays 8; old dims remain visible until each commit.
- Assert rst while in WAIT_COMMIT → all outputs 0 and table empty the same cycle (asynchronous); the first request after release grants slot 0.

Source files
------------

// File: rtl/matrix_slot_manager_pkg.sv
// Shared definitions for the matrix slot manager: error codes, FSM states,
// default geometry and the commit dimension check.
package matrix_slot_manager_pkg;

  localparam int unsigned BRAM_ADDR_WIDTH     = 10;
  localparam int unsigned DEFAULT_NUM_SLOTS   = 8;
  localparam int unsigned DEFAULT_SLOT_STRIDE = 32;

  localparam logic [3:0] ERR_NONE      = 4'd0;
  localparam logic [3:0] ERR_DIM_RANGE = 4'd1;
  localparam logic [3:0] ERR_NO_SLOT   = 4'd2;
  localparam logic [3:0] ERR_COMMIT    = 4'd3;

  typedef enum logic [1:0] {
    MSM_IDLE,
    MSM_SEARCH,
    MSM_GRANT,
    MSM_WAIT_COMMIT
  } msm_state_e;

  // True when an m x n matrix is non-empty and fits in one slot region.
  function automatic logic dims_fit(input logic [3:0] m, input logic [3:0] n,
                                    input int unsigned stride);
    logic [7:0] area;
    area = {4'b0, m} * {4'b0, n};
    return (m != '0) && (n != '0) && (32'(area) <= stride);
  endfunction

endpackage

// File: rtl/matrix_slot_manager_slot_priority_encoder.sv
// Lowest-index priority encoder over a free-resource mask.
// Returns the lowest set bit index and a found flag; generic for any pool.
module slot_priority_encoder #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     free_mask,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (free_mask[i-1]) begin
        idx   = IDX_W'(i - 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_slot_manager.sv
// Matrix storage table manager: reserves fixed-stride BRAM slots for the
// generate/input modes, records dimensions on commit and serves a
// registered lookup port. Never touches matrix data.
// Optional macro SLOT_OVERWRITE_EN: when the table is full, grant the
// round-robin victim slot instead of failing.
module matrix_slot_manager
  import matrix_slot_manager_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = DEFAULT_NUM_SLOTS,
  parameter int unsigned ADDR_WIDTH  = BRAM_ADDR_WIDTH,
  parameter int unsigned SLOT_STRIDE = DEFAULT_SLOT_STRIDE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  input  logic                  alloc_cancel,
  output logic                  alloc_valid,
  output logic                  alloc_fail,
  output logic [3:0]            alloc_slot,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  commit_req,
  input  logic [3:0]            commit_slot,
  input  logic [3:0]            commit_m,
  input  logic [3:0]            commit_n,
  input  logic [ADDR_WIDTH-1:0] commit_addr,
  input  logic [3:0]            q_slot,
  output logic                  q_valid,
  output logic [3:0]            q_m,
  output logic [3:0]            q_n,
  output logic [ADDR_WIDTH-1:0] q_addr,
  output logic [4:0]            slot_count,
  output logic [3:0]            error_code,
  output logic                  busy
);

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [3:0] s);
    return ADDR_WIDTH'(s) * ADDR_WIDTH'(SLOT_STRIDE);
  endfunction

  msm_state_e                     state_q, state_d;
  logic                           armed_q, armed_d;
  logic                           busy_q, busy_d;
  logic                           alloc_valid_q, alloc_valid_d;
  logic                           alloc_fail_q, alloc_fail_d;
  logic [3:0]                     alloc_slot_q, alloc_slot_d;
  logic [ADDR_WIDTH-1:0]          alloc_addr_q, alloc_addr_d;
  logic [3:0]                     error_q, error_d;
  logic [4:0]                     count_q, count_d;
  logic [NUM_SLOTS-1:0]           valid_q, valid_d;
  logic [NUM_SLOTS-1:0][3:0]      m_q, m_d;
  logic [NUM_SLOTS-1:0][3:0]      n_q, n_d;
  logic                           q_valid_q, q_valid_d;
  logic [3:0]                     q_m_q, q_m_d;
  logic [3:0]                     q_n_q, q_n_d;
  logic [ADDR_WIDTH-1:0]          q_addr_q, q_addr_d;

  logic [NUM_SLOTS-1:0]           reserved_mask;
  logic [NUM_SLOTS-1:0]           free_mask;
  logic [3:0]                     free_idx;
  logic                           free_found;
  logic                           pick_hit;
  logic [3:0]                     pick_slot;
  logic                           commit_match;
  logic                           newly_valid;

`ifdef SLOT_OVERWRITE_EN
  logic [3:0]                     victim_q, victim_d;
  logic                           victim_ok;
`endif

  // Free slots are those neither committed nor held by the outstanding reservation.
  always_comb begin
    reserved_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (busy_q && (4'(i) == alloc_slot_q)) reserved_mask[i] = 1'b1;
    end
    free_mask = ~valid_q & ~reserved_mask;
  end

  slot_priority_encoder #(
    .N     (NUM_SLOTS),
    .IDX_W (4)
  ) u_free_enc (
    .free_mask (free_mask),
    .idx       (free_idx),
    .found     (free_found)
  );

  // Next-state, reservation bookkeeping and table updates.
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q | ~alloc_req;
    busy_d        = busy_q;
    alloc_valid_d = 1'b0;
    alloc_fail_d  = 1'b0;
    alloc_slot_d  = alloc_slot_q;
    alloc_addr_d  = alloc_addr_q;
    error_d       = error_q;
    count_d       = count_q;
    valid_d       = valid_q;
    m_d           = m_q;
    n_d           = n_q;
    newly_valid   = 1'b0;
    pick_hit      = free_found;
    pick_slot     = free_idx;
`ifdef SLOT_OVERWRITE_EN
    victim_d      = victim_q;
    victim_ok     = (&valid_q) && !busy_q;
    if (!free_found && victim_ok) begin
      pick_hit  = 1'b1;
      pick_slot = victim_q;
    end
`endif

    commit_match = commit_req && busy_q &&
                   (commit_slot == alloc_slot_q) &&
                   (commit_addr == alloc_addr_q) &&
                   dims_fit(commit_m, commit_n, SLOT_STRIDE);

    if (commit_req && (state_q != MSM_WAIT_COMMIT)) error_d = ERR_COMMIT;

    case (state_q)
      MSM_IDLE: begin
        if (alloc_req && armed_q) state_d = MSM_SEARCH;
      end
      MSM_SEARCH: begin
        armed_d = 1'b0;
        if (pick_hit) begin
          busy_d        = 1'b1;
          alloc_slot_d  = pick_slot;
          alloc_addr_d  = base_of(pick_slot);
          alloc_valid_d = 1'b1;
          state_d       = MSM_GRANT;
`ifdef SLOT_OVERWRITE_EN
          if (!free_found) begin
            if (32'(victim_q) == NUM_SLOTS - 1) victim_d = '0;
            else                                victim_d = victim_q + 4'd1;
          end
`endif
        end else begin
          alloc_fail_d = 1'b1;
          error_d      = ERR_NO_SLOT;
          state_d      = MSM_IDLE;
        end
      end
      MSM_GRANT: begin
        state_d = MSM_WAIT_COMMIT;
      end
      MSM_WAIT_COMMIT: begin
        // A commit takes precedence over a same-cycle cancel or re-request.
        if (commit_req) begin
          if (commit_match) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              if (4'(i) == alloc_slot_q) begin
                newly_valid = ~valid_q[i];
                valid_d[i]  = 1'b1;
                m_d[i]      = commit_m;
                n_d[i]      = commit_n;
              end
            end
            if (newly_valid && (32'(count_q) < NUM_SLOTS)) count_d = count_q + 5'd1;
            busy_d  = 1'b0;
            error_d = ERR_NONE;
            state_d = MSM_IDLE;
          end else begin
            error_d = ERR_COMMIT;
          end
        end else if (alloc_cancel || (alloc_req && armed_q)) begin
          busy_d  = 1'b0;
          state_d = MSM_IDLE;
        end
      end
      default: state_d = MSM_IDLE;
    endcase
  end

  // Lookup read; out-of-range indices match no slot and return zeros.
  always_comb begin
    q_valid_d = 1'b0;
    q_m_d     = '0;
    q_n_d     = '0;
    q_addr_d  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (4'(i) == q_slot) begin
        q_valid_d = valid_q[i];
        q_m_d     = m_q[i];
        q_n_d     = n_q[i];
        q_addr_d  = base_of(q_slot);
      end
    end
  end

  // State, table and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= MSM_IDLE;
      armed_q       <= 1'b1;
      busy_q        <= 1'b0;
      alloc_valid_q <= 1'b0;
      alloc_fail_q  <= 1'b0;
      alloc_slot_q  <= '0;
      alloc_addr_q  <= '0;
      error_q       <= ERR_NONE;
      count_q       <= '0;
      valid_q       <= '0;
      m_q           <= '0;
      n_q           <= '0;
      q_valid_q     <= 1'b0;
      q_m_q         <= '0;
      q_n_q         <= '0;
      q_addr_q      <= '0;
`ifdef SLOT_OVERWRITE_EN
      victim_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      busy_q        <= busy_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_fail_q  <= alloc_fail_d;
      alloc_slot_q  <= alloc_slot_d;
      alloc_addr_q  <= alloc_addr_d;
      error_q       <= error_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      m_q           <= m_d;
      n_q           <= n_d;
      q_valid_q     <= q_valid_d;
      q_m_q         <= q_m_d;
      q_n_q         <= q_n_d;
      q_addr_q      <= q_addr_d;
`ifdef SLOT_OVERWRITE_EN
      victim_q      <= victim_d;
`endif
    end
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_fail  = alloc_fail_q;
  assign alloc_slot  = alloc_slot_q;
  assign alloc_addr  = alloc_addr_q;
  assign q_valid     = q_valid_q;
  assign q_m         = q_m_q;
  assign q_n         = q_n_q;
  assign q_addr      = q_addr_q;
  assign slot_count  = count_q;
  assign error_code  = error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Self-checking bench for matrix_slot_manager (8 slots, stride 32, 10-bit addr).
// Expected grants and lookups are queued when stimulus is driven and popped
// when the DUT responds. Honours SLOT_OVERWRITE_EN for the full-table case.
module tb_matrix_slot_manager;

  localparam int unsigned AW = 10;
  localparam logic [3:0] E_NONE    = 4'd0;
  localparam logic [3:0] E_NO_SLOT = 4'd2;
  localparam logic [3:0] E_COMMIT  = 4'd3;

  logic          clk, rst;
  logic          alloc_req, alloc_cancel, alloc_valid, alloc_fail;
  logic [3:0]    alloc_slot;
  logic [AW-1:0] alloc_addr;
  logic          commit_req;
  logic [3:0]    commit_slot, commit_m, commit_n;
  logic [AW-1:0] commit_addr;
  logic [3:0]    q_slot;
  logic          q_valid;
  logic [3:0]    q_m, q_n;
  logic [AW-1:0] q_addr;
  logic [4:0]    slot_count;
  logic [3:0]    error_code;
  logic          busy;

  matrix_slot_manager #(
    .NUM_SLOTS   (8),
    .ADDR_WIDTH  (AW),
    .SLOT_STRIDE (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_cancel (alloc_cancel),
    .alloc_valid  (alloc_valid),
    .alloc_fail   (alloc_fail),
    .alloc_slot   (alloc_slot),
    .alloc_addr   (alloc_addr),
    .commit_req   (commit_req),
    .commit_slot  (commit_slot),
    .commit_m     (commit_m),
    .commit_n     (commit_n),
    .commit_addr  (commit_addr),
    .q_slot       (q_slot),
    .q_valid      (q_valid),
    .q_m          (q_m),
    .q_n          (q_n),
    .q_addr       (q_addr),
    .slot_count   (slot_count),
    .error_code   (error_code),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] slot; logic [AW-1:0] addr; } grant_t;
  typedef struct packed { logic v; logic [3:0] m; logic [3:0] n; logic [AW-1:0] a; } look_t;

  grant_t grant_exp[$];
  look_t  look_exp[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant or fail pulse; cyc = 0 means none arrived.
  task automatic wait_alloc(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (alloc_valid || alloc_fail) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic request(output int cyc);
    alloc_req = 1'b1;
    wait_alloc(cyc);
    alloc_req = 1'b0;
  endtask

  task automatic drive_commit(input logic [3:0] s, input logic [3:0] m,
                              input logic [3:0] n, input logic [AW-1:0] a);
    commit_req  = 1'b1;
    commit_slot = s;
    commit_m    = m;
    commit_n    = n;
    commit_addr = a;
    tick();
    commit_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alloc_req = 0; alloc_cancel = 0; commit_req = 0;
    commit_slot = 0; commit_m = 0; commit_n = 0; commit_addr = 0; q_slot = 0;
    tick(); tick();
    checks++;
    if ({alloc_valid, alloc_fail, alloc_slot, alloc_addr, busy} !== '0) begin
      errors++; $display("FAIL reset_alloc: got %h expected 0", {alloc_valid, alloc_fail, alloc_slot, alloc_addr, busy});
    end
    checks++;
    if ({q_valid, q_m, q_n, q_addr, slot_count, error_code} !== {1'b0, 4'd0, 4'd0, 10'd0, 5'd0, E_NONE}) begin
      errors++; $display("FAIL reset_lookup: got %h expected 0", {q_valid, q_m, q_n, q_addr, slot_count, error_code});
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_first_grant();
    int cyc;
    grant_t g;
    look_t  l;
    grant_exp.push_back('{4'd0, 10'd0});
    request(cyc);
    g = grant_exp.pop_front();
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL grant_latency: got %0d expected 2", cyc); end
    checks++;
    if ({alloc_slot, alloc_addr} !== g) begin
      errors++; $display("FAIL first_grant: got %h expected %h", {alloc_slot, alloc_addr}, g);
    end
    tick();
    checks++;
    if ({busy, alloc_valid} !== 2'b10) begin
      errors++; $display("FAIL grant_pulse_busy: got %b expected 10", {busy, alloc_valid});
    end
    q_slot = 4'd0;
    look_exp.push_back('{1'b0, 4'd0, 4'd0, 10'd0});
    drive_commit(4'd0, 4'd3, 4'd4, 10'd0);
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_same_cycle_old: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
    look_exp.push_back('{1'b1, 4'd3, 4'd4, 10'd0});
    tick();
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_slot0: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
    checks++;
    if ({slot_count, busy, error_code} !== {5'd1, 1'b0, E_NONE}) begin
      errors++; $display("FAIL first_commit_state: got %h expected %h", {slot_count, busy, error_code}, {5'd1, 1'b0, E_NONE});
    end
  endtask

  task automatic test_held_request();
    int cyc, extra;
    grant_t g;
    grant_exp.push_back('{4'd1, 10'd32});
    alloc_req = 1'b1;
    wait_alloc(cyc);
    g = grant_exp.pop_front();
    checks++;
    if (cyc == 0 || {alloc_slot, alloc_addr} !== g) begin
      errors++; $display("FAIL held_grant: got %h (cyc %0d) expected %h", {alloc_slot, alloc_addr}, cyc, g);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (alloc_valid) extra++;
    end
    checks++;
    if (extra !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL held_no_double: got %0d extra grants busy %b expected 0 busy 1", extra, busy);
    end
    alloc_req = 1'b0;
    tick();
    grant_exp.push_back('{4'd1, 10'd32});
    request(cyc);
    g = grant_exp.pop_front();
    checks++;
    if (cyc == 0 || {alloc_slot, alloc_addr} !== g) begin
      errors++; $display("FAIL rearm_grant: got %h (cyc %0d) expected %h", {alloc_slot, alloc_addr}, cyc, g);
    end
    tick();
  endtask

  task automatic test_commit_mismatch();
    look_t l;
    drive_commit(4'd2, 4'd2, 4'd2, 10'd64);
    checks++;
    if ({error_code, busy} !== {E_COMMIT, 1'b1}) begin
      errors++; $display("FAIL wrong_slot_commit: got %h expected %h", {error_code, busy}, {E_COMMIT, 1'b1});
    end
    drive_commit(4'd1, 4'd2, 4'd5, 10'd32);
    checks++;
    if ({error_code, busy, slot_count} !== {E_NONE, 1'b0, 5'd2}) begin
      errors++; $display("FAIL good_commit: got %h expected %h", {error_code, busy, slot_count}, {E_NONE, 1'b0, 5'd2});
    end
    q_slot = 4'd1;
    look_exp.push_back('{1'b1, 4'd2, 4'd5, 10'd32});
    tick();
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_slot1: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
  endtask

  task automatic test_dims_and_cancel();
    int cyc;
    grant_t g;
    look_t  l;
    grant_exp.push_back('{4'd2, 10'd64});
    request(cyc);
    g = grant_exp.pop_front();
    checks++;
    if (cyc !== 2 || {alloc_slot, alloc_addr} !== g) begin
      errors++; $display("FAIL grant_slot2: got %h (cyc %0d) expected %h", {alloc_slot, alloc_addr}, cyc, g);
    end
    tick();
    drive_commit(4'd2, 4'd6, 4'd6, 10'd64);
    checks++;
    if ({error_code, busy} !== {E_COMMIT, 1'b1}) begin
      errors++; $display("FAIL oversize_commit: got %h expected %h", {error_code, busy}, {E_COMMIT, 1'b1});
    end
    drive_commit(4'd2, 4'd0, 4'd4, 10'd64);
    checks++;
    if ({error_code, busy} !== {E_COMMIT, 1'b1}) begin
      errors++; $display("FAIL zero_m_commit: got %h expected %h", {error_code, busy}, {E_COMMIT, 1'b1});
    end
    alloc_cancel = 1'b1;
    tick();
    alloc_cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    grant_exp.push_back('{4'd2, 10'd64});
    request(cyc);
    g = grant_exp.pop_front();
    checks++;
    if (cyc !== 2 || {alloc_slot, alloc_addr} !== g) begin
      errors++; $display("FAIL reuse_after_cancel: got %h (cyc %0d) expected %h", {alloc_slot, alloc_addr}, cyc, g);
    end
    tick();
    alloc_cancel = 1'b1;
    drive_commit(4'd2, 4'd4, 4'd8, 10'd64);
    alloc_cancel = 1'b0;
    checks++;
    if ({error_code, busy, slot_count} !== {E_NONE, 1'b0, 5'd3}) begin
      errors++; $display("FAIL commit_beats_cancel_32: got %h expected %h", {error_code, busy, slot_count}, {E_NONE, 1'b0, 5'd3});
    end
    drive_commit(4'd2, 4'd1, 4'd1, 10'd64);
    checks++;
    if ({error_code, slot_count} !== {E_COMMIT, 5'd3}) begin
      errors++; $display("FAIL idle_commit: got %h expected %h", {error_code, slot_count}, {E_COMMIT, 5'd3});
    end
    q_slot = 4'd2;
    look_exp.push_back('{1'b1, 4'd4, 4'd8, 10'd64});
    tick();
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_slot2: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
  endtask

  task automatic test_full_table();
    int cyc;
    grant_t g;
    for (int s = 3; s < 8; s++) begin
      grant_exp.push_back('{4'(s), 10'(s * 32)});
      request(cyc);
      g = grant_exp.pop_front();
      checks++;
      if (cyc == 0 || {alloc_slot, alloc_addr} !== g) begin
        errors++; $display("FAIL fill_grant_%0d: got %h expected %h", s, {alloc_slot, alloc_addr}, g);
      end
      tick();
      drive_commit(4'(s), 4'd1, 4'(s + 1), 10'(s * 32));
    end
    checks++;
    if (slot_count !== 5'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", slot_count); end
`ifndef SLOT_OVERWRITE_EN
    request(cyc);
    checks++;
    if (cyc !== 2 || {alloc_fail, alloc_valid} !== 2'b10) begin
      errors++; $display("FAIL full_alloc_fail: got fail/valid %b cyc %0d expected 10 cyc 2", {alloc_fail, alloc_valid}, cyc);
    end
    checks++;
    if ({error_code, busy, slot_count} !== {E_NO_SLOT, 1'b0, 5'd8}) begin
      errors++; $display("FAIL full_no_slot: got %h expected %h", {error_code, busy, slot_count}, {E_NO_SLOT, 1'b0, 5'd8});
    end
    tick();
    checks++;
    if (alloc_fail !== 1'b0) begin errors++; $display("FAIL fail_pulse_width: got %b expected 0", alloc_fail); end
`else
    begin
      logic [3:0] om [0:2];
      logic [3:0] on [0:2];
      look_t l;
      om[0] = 4'd3; om[1] = 4'd2; om[2] = 4'd4;
      on[0] = 4'd4; on[1] = 4'd5; on[2] = 4'd8;
      for (int v = 0; v < 3; v++) begin
        grant_exp.push_back('{4'(v), 10'(v * 32)});
        request(cyc);
        g = grant_exp.pop_front();
        checks++;
        if (cyc !== 2 || alloc_valid !== 1'b1 || {alloc_slot, alloc_addr} !== g) begin
          errors++; $display("FAIL overwrite_grant_%0d: got %h valid %b expected %h", v, {alloc_slot, alloc_addr}, alloc_valid, g);
        end
        q_slot = 4'(v);
        look_exp.push_back('{1'b1, om[v], on[v], 10'(v * 32)});
        tick();
        l = look_exp.pop_front();
        checks++;
        if ({q_valid, q_m, q_n, q_addr} !== l) begin
          errors++; $display("FAIL overwrite_old_dims_%0d: got %h expected %h", v, {q_valid, q_m, q_n, q_addr}, l);
        end
        drive_commit(4'(v), 4'd2, 4'd2, 10'(v * 32));
        look_exp.push_back('{1'b1, 4'd2, 4'd2, 10'(v * 32)});
        tick();
        l = look_exp.pop_front();
        checks++;
        if ({q_valid, q_m, q_n, q_addr, slot_count} !== {l, 5'd8}) begin
          errors++; $display("FAIL overwrite_new_dims_%0d: got %h expected %h", v, {q_valid, q_m, q_n, q_addr, slot_count}, {l, 5'd8});
        end
      end
    end
`endif
  endtask

  task automatic test_lookup_bounds();
    look_t l;
    q_slot = 4'd8;
    look_exp.push_back('{1'b0, 4'd0, 4'd0, 10'd0});
    tick();
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_oob8: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
    q_slot = 4'd7;
    look_exp.push_back('{1'b1, 4'd1, 4'd8, 10'd224});
    tick();
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_slot7: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
    q_slot = 4'd15;
    look_exp.push_back('{1'b0, 4'd0, 4'd0, 10'd0});
    tick();
    l = look_exp.pop_front();
    checks++;
    if ({q_valid, q_m, q_n, q_addr} !== l) begin
      errors++; $display("FAIL lookup_oob15: got %h expected %h", {q_valid, q_m, q_n, q_addr}, l);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    grant_t g;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    request(cyc);
    tick();
    drive_commit(4'd0, 4'd2, 4'd2, 10'd0);
    request(cyc);
    tick();
    q_slot = 4'd0;
    tick();
    checks++;
    if ({busy, alloc_slot, slot_count, q_valid} !== {1'b1, 4'd1, 5'd1, 1'b1}) begin
      errors++; $display("FAIL pre_reset_state: got %h expected %h", {busy, alloc_slot, slot_count, q_valid}, {1'b1, 4'd1, 5'd1, 1'b1});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, alloc_slot, alloc_addr, slot_count, q_valid, q_m, q_n, error_code} !== '0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {busy, alloc_slot, alloc_addr, slot_count, q_valid, q_m, q_n, error_code});
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL table_cleared: got %b expected 0", q_valid); end
    grant_exp.push_back('{4'd0, 10'd0});
    request(cyc);
    g = grant_exp.pop_front();
    checks++;
    if (cyc !== 2 || {alloc_slot, alloc_addr} !== g) begin
      errors++; $display("FAIL post_reset_grant: got %h (cyc %0d) expected %h", {alloc_slot, alloc_addr}, cyc, g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_grant();
    test_held_request();
    test_commit_mismatch();
    test_dims_and_cancel();
    test_full_table();
    test_lookup_bounds();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
